// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: alignment op codes, direction-symbol
// bit positions (also used by the scoring stage) and the traceback FSM states.
package nw_pkg;

   localparam int SYM_DIAG = 2;
   localparam int SYM_UP   = 1;
   localparam int SYM_LX   = 0;

   typedef enum logic [1:0] {
      OP_DIAG = 2'b00,
      OP_UP   = 2'b01,
      OP_LEFT = 2'b10
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_EMIT,
      ST_FIN
   } state_e;

endpackage

// File: rtl/nw_traceback_if.sv
// Traceback bundle: control, direction-memory read port and op output stream.
interface nw_traceback_if
   import nw_pkg::*;
#(
   parameter int N      = 8,
   parameter int IDX_W  = $clog2(N+1),
   parameter int ADDR_W = $clog2((N+1)*(N+1))
);
   logic              start;
   logic              sym_rd_en;
   logic [ADDR_W-1:0] sym_addr;
   logic [2:0]        sym_data;
   logic              out_valid;
   logic              out_ready;
   op_e               out_op;
   logic [IDX_W-1:0]  out_i;
   logic [IDX_W-1:0]  out_j;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      input  start, sym_data, out_ready,
      output sym_rd_en, sym_addr, out_valid, out_op, out_i, out_j,
             busy, done, error
   );

   modport slave (
      output start, sym_data, out_ready,
      input  sym_rd_en, sym_addr, out_valid, out_op, out_i, out_j,
             busy, done, error
   );
endinterface

// File: rtl/nw_sym_decode.sv
// Priority decode of a direction symbol: diag beats up beats left; an empty
// symbol means the scoring stage left no predecessor, which is illegal.
module nw_sym_decode
   import nw_pkg::*;
(
   input  logic [2:0] sym,
   output op_e        op,
   output logic       illegal
);

   // diag > up > lx priority
   always_comb begin
      op      = OP_DIAG;
      illegal = 1'b0;
      if (sym[SYM_DIAG])    op = OP_DIAG;
      else if (sym[SYM_UP]) op = OP_UP;
      else if (sym[SYM_LX]) op = OP_LEFT;
      else                  illegal = 1'b1;
   end

endmodule

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks from (N,N) to (0,0) reading direction
// symbols and streams one alignment op per step over valid/ready.
module nw_traceback
   import nw_pkg::*;
#(
   parameter int N      = 8,
   parameter int IDX_W  = $clog2(N+1),
   parameter int ADDR_W = $clog2((N+1)*(N+1))
) (
   input  logic           clk,
   input  logic           rst,
   nw_traceback_if.master bus
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
   op_e              op_q, op_d;
   logic             err_q, err_d;

   op_e              dec_op;
   logic             dec_illegal;
   logic             at_edge;
   logic [ADDR_W-1:0] cell_addr;

   nw_sym_decode u_dec (
      .sym     (bus.sym_data),
      .op      (dec_op),
      .illegal (dec_illegal)
   );

   // On row 0 or column 0 the only legal move is forced, so no read is needed
   assign at_edge   = (i_q == '0) || (j_q == '0);
   assign cell_addr = ADDR_W'(i_q) * ADDR_W'(N+1) + ADDR_W'(j_q);

   // State, indices, latched op and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         op_q    <= OP_DIAG;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         op_q    <= op_d;
         err_q   <= err_d;
      end
   end

   // Next-state and index/op updates
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      op_d    = op_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               i_d     = IDX_W'(N);
               j_d     = IDX_W'(N);
               err_d   = 1'b0;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (at_edge) begin
               op_d    = (i_q == '0) ? OP_LEFT : OP_UP;
               state_d = ST_EMIT;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dec_illegal) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end else begin
               op_d    = dec_op;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (bus.out_ready) begin
               unique case (op_q)
                  OP_DIAG: begin
                     i_d = i_q - IDX_W'(1);
                     j_d = j_q - IDX_W'(1);
                  end
                  OP_UP:   i_d = i_q - IDX_W'(1);
                  default: j_d = j_q - IDX_W'(1);
               endcase
               state_d = ((i_d == '0) && (j_d == '0)) ? ST_FIN : ST_READ;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode straight from state so reset zeroes them immediately
   assign bus.sym_rd_en = (state_q == ST_READ) && !at_edge;
   assign bus.sym_addr  = bus.sym_rd_en ? cell_addr : '0;
   assign bus.out_valid = (state_q == ST_EMIT);
   assign bus.out_op    = bus.out_valid ? op_q : OP_DIAG;
   assign bus.out_i     = bus.out_valid ? i_q : '0;
   assign bus.out_j     = bus.out_valid ? j_q : '0;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_FIN);
   assign bus.error     = err_q;

endmodule
